// File: rtl/crc16_pkg.sv
// Shared definitions for the downlink CRC-16 checker: command classes,
// opcode constants, CRC-16 constants, per-class minimum lengths, FSM states.
package crc16_pkg;

    // Command classes reported to the command FSM
    typedef enum logic [2:0] {
        CLS_NONE     = 3'd0,
        CLS_SELECT   = 3'd1,
        CLS_REQRN    = 3'd2,
        CLS_READ     = 3'd3,
        CLS_WRITE    = 3'd4,
        CLS_SENSDATA = 3'd5
    } cmd_class_e;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECV   = 2'd1,
        ST_EVAL   = 2'd2,
        ST_RESULT = 2'd3
    } state_e;

    // Opcodes of the CRC-16 protected commands
    localparam logic [7:0] OPC_REQRN     = 8'hC1;
    localparam logic [7:0] OPC_READ      = 8'hC2;
    localparam logic [7:0] OPC_WRITE     = 8'hC3;
    localparam logic [3:0] SELECT_PREFIX = 4'b1010;

    // CRC-16 (x^16 + x^12 + x^5 + 1), preset and good-packet residue
    localparam logic [15:0] CRC16_POLY    = 16'h1021;
    localparam logic [15:0] CRC16_PRESET  = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUE = 16'h1D0F;

    // Minimum packet lengths in bits
    localparam logic [8:0] MINLEN_SELECT = 9'd44;
    localparam logic [8:0] MINLEN_REQRN  = 9'd40;
    localparam logic [8:0] MINLEN_READ   = 9'd58;
    localparam logic [8:0] MINLEN_WRITE  = 9'd66;

    // Minimum legal length of a packet of the given class
    function automatic logic [8:0] class_min_len(input cmd_class_e cls,
                                                 input logic [8:0] sens_min);
        case (cls)
            CLS_SELECT:   return MINLEN_SELECT;
            CLS_REQRN:    return MINLEN_REQRN;
            CLS_READ:     return MINLEN_READ;
            CLS_WRITE:    return MINLEN_WRITE;
            CLS_SENSDATA: return sens_min;
            default:      return 9'd0;
        endcase
    endfunction

endpackage

// File: rtl/crc16_check_ctrl_if.sv
// Bit-stream input and result handshake between demodulator / command FSM
// (master) and the CRC-16 check controller (slave).
interface crc16_check_ctrl_if;

    logic        pkt_start;
    logic        bit_valid;
    logic        bit_in;
    logic        pkt_end;
    logic        result_ack;
    logic        busy;
    logic        crc_needed;
    logic [2:0]  cmd_class;
    logic        crc_valid;
    logic        crc_ok;
    logic        len_err;
    logic [8:0]  bit_count;
    logic [15:0] crc_value;

    modport master (
        output pkt_start, bit_valid, bit_in, pkt_end, result_ack,
        input  busy, crc_needed, cmd_class, crc_valid, crc_ok, len_err,
               bit_count, crc_value
    );

    modport slave (
        input  pkt_start, bit_valid, bit_in, pkt_end, result_ack,
        output busy, crc_needed, cmd_class, crc_valid, crc_ok, len_err,
               bit_count, crc_value
    );

endinterface

// File: rtl/crc16_lfsr.sv
// Bit-serial CRC-16 LFSR, x^16 + x^12 + x^5 + 1, MSB-first.
// clr presets to FFFF; clr together with en shifts the bit into the preset.
module crc16_lfsr
    import crc16_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic        bitin,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;
    logic [15:0] base;
    logic        fb;

    // Next LFSR value: optional preset, then optional one-bit shift
    always_comb begin
        base  = clr ? CRC16_PRESET : crc_q;
        fb    = bitin ^ base[15];
        crc_d = base;
        if (en) begin
            crc_d = {base[14:0], 1'b0} ^ ({16{fb}} & CRC16_POLY);
        end
    end

    // LFSR register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc_q <= CRC16_PRESET;
        end else begin
            // NOTE: non-blocking assignment for every flop so all registers
            // update from the same pre-edge values.
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/crc16_check_ctrl.sv
// CRC-16 check controller for downlink packets: counts bits, classifies the
// command from its opcode, drives the LFSR and reports pass/fail with a
// valid/ack handshake.
module crc16_check_ctrl
    import crc16_pkg::*;
#(
    parameter int         MAX_BITS        = 511,
    parameter logic [7:0] SENSDATA_OPCODE = 8'hE0,
    parameter int         SENSDATA_MINLEN = 40
) (
    input logic               clk,
    input logic               reset,
    crc16_check_ctrl_if.slave bus
);

    localparam logic [8:0] MAX_CNT  = 9'(MAX_BITS);
    localparam logic [8:0] SENS_MIN = 9'(SENSDATA_MINLEN);

    state_e     state_q, state_d;
    logic [8:0] count_q, count_d;
    logic [6:0] prefix_q, prefix_d;   // first seven opcode bits
    cmd_class_e class_q, class_d;
    logic       overflow_q, overflow_d;
    logic       len_err_q, len_err_d;
    logic       crc_ok_q, crc_ok_d;
    logic       crc_valid_q, crc_valid_d;

    logic        busy;
    logic        accept;
    logic [7:0]  opcode_next;
    logic [15:0] crc;
    logic        crc_needed;
    logic        eval_len_err;

    // Bits are taken in RECV, and as bit 0 alongside pkt_start in any state
    assign accept      = bus.bit_valid && (bus.pkt_start || (state_q == ST_RECV));
    // The eighth opcode bit is the incoming one at the deciding cycle
    assign opcode_next = {prefix_q, bus.bit_in};
    assign crc_needed  = (class_q != CLS_NONE);
    assign eval_len_err = overflow_q || (count_q < class_min_len(class_q, SENS_MIN));

    crc16_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.pkt_start),
        .en    (accept),
        .bitin (bus.bit_in),
        .crc   (crc)
    );

    // Next-state logic and busy flag; pkt_start overrides every transition
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // can leave it unassigned and infer a latch.
        state_d = state_q;
        busy    = 1'b0;
        case (state_q)
            ST_IDLE: ;
            ST_RECV: begin
                busy = 1'b1;
                if (bus.pkt_end) state_d = ST_EVAL;
            end
            ST_EVAL: begin
                busy    = 1'b1;
                state_d = ST_RESULT;
            end
            ST_RESULT: begin
                if (bus.result_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.pkt_start) state_d = ST_RECV;
    end

    // Bit counter, opcode capture, classifier and result evaluation
    always_comb begin
        count_d     = count_q;
        prefix_d    = prefix_q;
        class_d     = class_q;
        overflow_d  = overflow_q;
        len_err_d   = len_err_q;
        crc_ok_d    = crc_ok_q;
        crc_valid_d = crc_valid_q;

        if (bus.pkt_start) begin
            count_d     = accept ? 9'd1 : 9'd0;
            prefix_d    = accept ? {6'd0, bus.bit_in} : 7'd0;
            class_d     = CLS_NONE;
            overflow_d  = 1'b0;
            len_err_d   = 1'b0;
            crc_ok_d    = 1'b0;
            crc_valid_d = 1'b0;
        end else begin
            if (accept) begin
                if (count_q == MAX_CNT) begin
                    overflow_d = 1'b1;
                end else begin
                    count_d = count_q + 9'd1;
                end
                if (count_q < 9'd7) begin
                    prefix_d = opcode_next[6:0];
                end
                // Bit 4 decides SELECT; bit 8 decides the full opcodes
                if (count_q == 9'd3 && opcode_next[3:0] == SELECT_PREFIX) begin
                    class_d = CLS_SELECT;
                end
                if (count_q == 9'd7 && class_q != CLS_SELECT) begin
                    if (opcode_next == OPC_REQRN)            class_d = CLS_REQRN;
                    else if (opcode_next == OPC_READ)        class_d = CLS_READ;
                    else if (opcode_next == OPC_WRITE)       class_d = CLS_WRITE;
                    else if (opcode_next == SENSDATA_OPCODE) class_d = CLS_SENSDATA;
                    else                                     class_d = CLS_NONE;
                end
            end
            if (state_q == ST_EVAL) begin
                len_err_d   = eval_len_err;
                crc_ok_d    = crc_needed && !eval_len_err && (crc == CRC16_RESIDUE);
                crc_valid_d = 1'b1;
            end
            if (state_q == ST_RESULT && bus.result_ack) begin
                len_err_d   = 1'b0;
                crc_ok_d    = 1'b0;
                crc_valid_d = 1'b0;
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            count_q     <= 9'd0;
            prefix_q    <= 7'd0;
            class_q     <= CLS_NONE;
            overflow_q  <= 1'b0;
            len_err_q   <= 1'b0;
            crc_ok_q    <= 1'b0;
            crc_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            prefix_q    <= prefix_d;
            class_q     <= class_d;
            overflow_q  <= overflow_d;
            len_err_q   <= len_err_d;
            crc_ok_q    <= crc_ok_d;
            crc_valid_q <= crc_valid_d;
        end
    end

    assign bus.busy       = busy;
    assign bus.crc_needed = crc_needed;
    assign bus.cmd_class  = class_q;
    assign bus.crc_valid  = crc_valid_q;
    assign bus.crc_ok     = crc_ok_q;
    assign bus.len_err    = len_err_q;
    assign bus.bit_count  = count_q;
    assign bus.crc_value  = crc;

endmodule

// File: tb/tb_crc16_check_ctrl.sv
// Directed-vector bench for crc16_check_ctrl with a result scoreboard.
module tb_crc16_check_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    longint cyc;

    crc16_check_ctrl_if bus ();

    crc16_check_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        logic [2:0] cls;
        logic       ok;
        logic       len;
        longint     at;
    } exp_t;

    exp_t sb[$];
    logic pkt[0:1023];
    logic valid_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Golden CRC-16: mask form of the generator, preset FFFF
    function automatic logic [15:0] crc_model(input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            if (pkt[i] ^ c[15]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else                c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    task automatic put_bits(input int start, input logic [63:0] val, input int width);
        for (int i = 0; i < width; i++) pkt[start + i] = val[width - 1 - i];
    endtask

    // Appends the transmitted (complemented) CRC after n bits
    task automatic append_crc(input int n);
        logic [15:0] c;
        c = ~crc_model(n);
        put_bits(n, {48'd0, c}, 16);
    endtask

    task automatic clear_inputs();
        bus.pkt_start  = 1'b0;
        bus.bit_valid  = 1'b0;
        bus.bit_in     = 1'b0;
        bus.pkt_end    = 1'b0;
        bus.result_ack = 1'b0;
    endtask

    // Drives n bits, pkt_start with bit 0 and pkt_end with the last bit
    task automatic send_pkt(input int n, output longint end_cyc);
        end_cyc = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.pkt_start = (i == 0);
            bus.bit_valid = 1'b1;
            bus.bit_in    = pkt[i];
            bus.pkt_end   = (i == n - 1);
            if (i == n - 1) end_cyc = cyc;
        end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic expect_result(input logic [2:0] cls, input logic ok,
                                 input logic len, input longint end_cyc);
        exp_t e;
        e.cls = cls; e.ok = ok; e.len = len; e.at = end_cyc + 2;
        sb.push_back(e);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!bus.crc_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid_timeout"}, {31'd0, bus.crc_valid}, 32'd1);
    endtask

    task automatic ack_result(input string name);
        @(posedge clk); #1;
        bus.result_ack = 1'b1;
        check({name, "_valid_before_ack"}, {31'd0, bus.crc_valid}, 32'd1);
        @(posedge clk); #1;
        bus.result_ack = 1'b0;
        @(negedge clk);
        check({name, "_valid_after_ack"}, {31'd0, bus.crc_valid}, 32'd0);
    endtask

    // Monitor: pops the scoreboard on each rising crc_valid
    initial valid_prev = 1'b0;
    always @(negedge clk) begin
        if (reset && bus.crc_valid && !valid_prev) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_cmd_class", {29'd0, bus.cmd_class}, {29'd0, e.cls});
                check("sb_crc_ok", {31'd0, bus.crc_ok}, {31'd0, e.ok});
                check("sb_len_err", {31'd0, bus.len_err}, {31'd0, e.len});
                check("sb_crc_needed", {31'd0, bus.crc_needed}, {31'd0, e.cls != 3'd0});
                check("sb_latency", 32'(cyc), 32'(e.at));
            end
        end
        valid_prev = reset ? bus.crc_valid : 1'b0;
    end

    initial begin
        longint ec;
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_crc_valid", {31'd0, bus.crc_valid}, 32'd0);
        check("rst_cmd_class", {29'd0, bus.cmd_class}, 32'd0);
        check("rst_bit_count", {23'd0, bus.bit_count}, 32'd0);
        check("rst_crc_value", {16'd0, bus.crc_value}, 32'h0000FFFF);
        @(posedge clk); #1;
        reset = 1'b1;

        // ReqRN C1 + 5A3C + CRC, good
        put_bits(0, 64'hC1, 8);
        put_bits(8, 64'h5A3C, 16);
        append_crc(24);
        send_pkt(40, ec);
        expect_result(3'd2, 1'b1, 1'b0, ec);
        wait_valid("reqrn");
        check("reqrn_residue", {16'd0, bus.crc_value}, 32'h00001D0F);
        check("reqrn_bit_count", {23'd0, bus.bit_count}, 32'd40);
        ack_result("reqrn");

        // Same ReqRN with bit 20 flipped: CRC failure, result held until ack
        pkt[20] = ~pkt[20];
        send_pkt(40, ec);
        expect_result(3'd2, 1'b0, 1'b0, ec);
        wait_valid("reqrn_bad");
        repeat (3) @(negedge clk);
        check("reqrn_bad_hold_valid", {31'd0, bus.crc_valid}, 32'd1);
        check("reqrn_bad_hold_ok", {31'd0, bus.crc_ok}, 32'd0);
        ack_result("reqrn_bad");

        // Select truncated to 30 bits with a valid CRC
        put_bits(0, 64'hA, 4);
        put_bits(4, 64'h2A5, 10);
        append_crc(14);
        send_pkt(30, ec);
        expect_result(3'd1, 1'b0, 1'b1, ec);
        wait_valid("select_short");
        check("select_short_residue", {16'd0, bus.crc_value}, 32'h00001D0F);
        ack_result("select_short");

        // QueryRep: four zero bits, class NONE
        put_bits(0, 64'h0, 4);
        send_pkt(4, ec);
        expect_result(3'd0, 1'b0, 1'b0, ec);
        wait_valid("queryrep");
        ack_result("queryrep");

        // Read C2 + 34 bits + CRC = 58 bits, good
        put_bits(0, 64'hC2, 8);
        put_bits(8, 64'h2_DEAD_BEEF, 34);
        append_crc(42);
        send_pkt(58, ec);
        expect_result(3'd3, 1'b1, 1'b0, ec);
        wait_valid("read");

        // pkt_start with bit_valid during RESULT drops the result
        @(posedge clk); #1;
        bus.pkt_start = 1'b1;
        bus.bit_valid = 1'b1;
        bus.bit_in    = 1'b1;
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        check("restart_crc_valid", {31'd0, bus.crc_valid}, 32'd0);
        check("restart_bit_count", {23'd0, bus.bit_count}, 32'd1);
        check("restart_crc_value", {16'd0, bus.crc_value}, 32'h0000FFFE);
        check("restart_busy", {31'd0, bus.busy}, 32'd1);

        // SensData E0 + 16 bits + CRC = 40 bits, good
        put_bits(0, 64'hE0, 8);
        put_bits(8, 64'h1234, 16);
        append_crc(24);
        send_pkt(40, ec);
        expect_result(3'd5, 1'b1, 1'b0, ec);
        wait_valid("sensdata");
        ack_result("sensdata");

        // pkt_end while IDLE is ignored
        @(posedge clk); #1;
        bus.pkt_end = 1'b1;
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        check("idle_pkt_end_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        check("idle_pkt_end_valid", {31'd0, bus.crc_valid}, 32'd0);

        // Write of 600 bits overflows
        put_bits(0, 64'hC3, 8);
        for (int i = 8; i < 600; i++) pkt[i] = (i % 3 == 0);
        send_pkt(600, ec);
        expect_result(3'd4, 1'b0, 1'b1, ec);
        wait_valid("write_long");
        check("write_long_bit_count", {23'd0, bus.bit_count}, 32'd511);
        ack_result("write_long");

        // Reset asserted in the middle of RECV
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            bus.pkt_start = (i == 0);
            bus.bit_valid = 1'b1;
            bus.bit_in    = pkt[i];
        end
        @(posedge clk); #1;
        clear_inputs();
        check("mid_recv_busy", {31'd0, bus.busy}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("async_rst_bit_count", {23'd0, bus.bit_count}, 32'd0);
        check("async_rst_cmd_class", {29'd0, bus.cmd_class}, 32'd0);
        check("async_rst_crc_needed", {31'd0, bus.crc_needed}, 32'd0);
        check("async_rst_crc_value", {16'd0, bus.crc_value}, 32'h0000FFFF);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(negedge clk);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
